// File: rtl/core_run_pkg.sv
// Shared types and parameter defaults for the core run sequencer.
package core_run_pkg;

  localparam int NUM_CORES_DEF  = 2;
  localparam int RST_CYCLES_DEF = 2;
  localparam int CNT_W_DEF      = 32;
  localparam int TIMEOUT_DEF    = 100000;

  // Sequencer phases: idle, holding cores in reset, executing, finished, watchdog expired.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RESET = 3'd1,
    ST_RUN   = 3'd2,
    ST_DONE  = 3'd3,
    ST_TMO   = 3'd4
  } core_run_state_e;

endpackage

// File: rtl/core_run_ctrl_if.sv
// Control/status bundle between the sequencer and its run-cycle counter.
// Handshake: there is no valid/ready pair here; clear and enable are level
// controls sampled on every rising edge (clear wins over enable), and count
// is the registered counter value, valid every cycle.
interface core_run_ctrl_if
  import core_run_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) ();

  logic             clear;
  logic             enable;
  logic             saturate;
  logic [CNT_W-1:0] count;

  modport master (output clear, output enable, output saturate, input count);
  modport slave  (input clear, input enable, input saturate, output count);

endinterface

// File: rtl/run_cycle_counter.sv
// Cycle counter with synchronous clear and optional saturation at all-ones.
module run_cycle_counter
  import core_run_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  core_run_ctrl_if.slave  cnt_if
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear has priority; when saturating, hold at all-ones.
  always_comb begin
    count_d = count_q;
    if (cnt_if.clear) begin
      count_d = '0;
    end else if (cnt_if.enable) begin
      if (!(cnt_if.saturate && (&count_q))) begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign cnt_if.count = count_q;

endmodule

// File: rtl/core_run_ctrl.sv
// Sequences a group of CPU cores through reset, run and halt/timeout completion.
module core_run_ctrl
  import core_run_pkg::*;
#(
  parameter int NUM_CORES  = NUM_CORES_DEF,
  parameter int RST_CYCLES = RST_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 start,
  input  logic [NUM_CORES-1:0] halt,
  output logic [NUM_CORES-1:0] core_rst,
  output logic                 run,
  output logic [NUM_CORES-1:0] halted,
  output logic [CNT_W-1:0]     cycle_cnt,
  output logic                 done,
  output logic                 timeout,
  output core_run_state_e      dbg_state
);

  if (RST_CYCLES < 1 || RST_CYCLES > 255) begin : g_bad_rst_cycles
    $error("core_run_ctrl: RST_CYCLES must be in 1..255");
  end
  if (NUM_CORES < 1 || NUM_CORES > 8) begin : g_bad_num_cores
    $error("core_run_ctrl: NUM_CORES must be in 1..8");
  end

  // A limit the counter cannot represent can never be reached, so it disables the watchdog.
  localparam bit               TMO_EN  = (TIMEOUT != 0) && ($clog2(TIMEOUT) <= CNT_W);
  localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT - 1);
  localparam logic [7:0]       RST_END = 8'(RST_CYCLES - 1);

  core_run_state_e      state_q, state_d;
  logic [7:0]           rst_cnt_q, rst_cnt_d;
  logic [NUM_CORES-1:0] halted_q, halted_d;
  logic [NUM_CORES-1:0] core_rst_q, core_rst_d;
  logic                 run_q, run_d;
  logic                 done_q, done_d;
  logic                 tmo_q, tmo_d;
  logic                 start_acc;
  logic                 all_halted;
  logic                 tmo_hit;

  core_run_ctrl_if #(.CNT_W(CNT_W)) cnt_if ();

  // start is only honoured while no run is in progress.
  assign start_acc  = start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_TMO);
  assign all_halted = &(halted_q | halt);
  assign tmo_hit    = TMO_EN && (cnt_if.count == TMO_CNT);

  assign cnt_if.clear    = start_acc;
  assign cnt_if.enable   = (state_q == ST_RUN);
  assign cnt_if.saturate = 1'b1;

  run_cycle_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk_i  (Clk),
    .rst_ni (Reset),
    .cnt_if (cnt_if.slave)
  );

  // State register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; completion outranks the watchdog in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RESET;
      ST_RESET: if (rst_cnt_q == RST_END) state_d = ST_RUN;
      ST_RUN: begin
        if (all_halted)   state_d = ST_DONE;
        else if (tmo_hit) state_d = ST_TMO;
      end
      ST_DONE:  if (start) state_d = ST_RESET;
      ST_TMO:   if (start) state_d = ST_RESET;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode from the next state, so the registered outputs track the state register.
  always_comb begin
    core_rst_d = (state_d == ST_RUN) ? '0 : '1;
    run_d      = (state_d == ST_RUN);
    done_d     = (state_d == ST_DONE);
    tmo_d      = (state_d == ST_TMO);
  end

  // Reset-hold counter and sticky halt record next values.
  always_comb begin
    rst_cnt_d = (state_q == ST_RESET) ? rst_cnt_q + 8'd1 : 8'd0;
    halted_d  = halted_q;
    if (start_acc) begin
      halted_d = '0;
    end else if (state_q == ST_RUN) begin
      halted_d = halted_q | halt;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rst_cnt_q  <= 8'd0;
      halted_q   <= '0;
      core_rst_q <= '1;
      run_q      <= 1'b0;
      done_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      rst_cnt_q  <= rst_cnt_d;
      halted_q   <= halted_d;
      core_rst_q <= core_rst_d;
      run_q      <= run_d;
      done_q     <= done_d;
      tmo_q      <= tmo_d;
    end
  end

  assign core_rst  = core_rst_q;
  assign run       = run_q;
  assign halted    = halted_q;
  assign cycle_cnt = cnt_if.count;
  assign done      = done_q;
  assign timeout   = tmo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl: DUT a (TIMEOUT=50) covers sequencing, halts, watchdog
// and reset abort; DUT b (CNT_W=4, TIMEOUT=0) covers counter saturation.
module tb_core_run_ctrl;
  import core_run_pkg::*;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  logic        start_a = 1'b0, start_b = 1'b0;
  logic [1:0]  halt_a = 2'b00, halt_b = 2'b00;
  logic [1:0]  core_rst_a, core_rst_b, halted_a, halted_b;
  logic        run_a, run_b, done_a, done_b, tmo_a, tmo_b;
  logic [31:0] cnt_a;
  logic [3:0]  cnt_b;
  core_run_state_e dbg_a, dbg_b;

  core_run_ctrl #(.NUM_CORES(2), .RST_CYCLES(2), .CNT_W(32), .TIMEOUT(50)) dut_a (
    .Clk(Clk), .Reset(Reset), .start(start_a), .halt(halt_a), .core_rst(core_rst_a),
    .run(run_a), .halted(halted_a), .cycle_cnt(cnt_a), .done(done_a), .timeout(tmo_a),
    .dbg_state(dbg_a)
  );

  core_run_ctrl #(.NUM_CORES(2), .RST_CYCLES(2), .CNT_W(4), .TIMEOUT(0)) dut_b (
    .Clk(Clk), .Reset(Reset), .start(start_b), .halt(halt_b), .core_rst(core_rst_b),
    .run(run_b), .halted(halted_b), .cycle_cnt(cnt_b), .done(done_b), .timeout(tmo_b),
    .dbg_state(dbg_b)
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    int         rst_left;
    bit         running;
    longint     cnt;
    logic [1:0] halted;
    bit         done;
    bit         tmo;
  } model_t;

  function automatic model_t model_reset();
    model_t m;
    m.rst_left = 0; m.running = 1'b0; m.cnt = 0; m.halted = 2'b00; m.done = 1'b0; m.tmo = 1'b0;
    return m;
  endfunction

  // One clock edge of the run rules: reset hold, run with halts/watchdog, or wait for start.
  function automatic model_t model_step(model_t m, bit st, logic [1:0] h, int rst_cycles,
                                        longint cnt_max, longint tmo_lim);
    model_t n = m;
    if (m.rst_left > 0) begin
      n.rst_left = m.rst_left - 1;
      if (n.rst_left == 0) n.running = 1'b1;
    end else if (m.running) begin
      n.halted = m.halted | h;
      if (m.cnt < cnt_max) n.cnt = m.cnt + 1;
      if (n.halted == 2'b11) begin
        n.running = 1'b0; n.done = 1'b1;
      end else if (tmo_lim != 0 && m.cnt == tmo_lim - 1) begin
        n.running = 1'b0; n.tmo = 1'b1;
      end
    end else if (st) begin
      n.rst_left = rst_cycles; n.cnt = 0; n.halted = 2'b00; n.done = 1'b0; n.tmo = 1'b0;
    end
    return n;
  endfunction

  model_t ma = model_reset();
  model_t mb = model_reset();

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ma <= model_reset();
      mb <= model_reset();
    end else begin
      ma <= model_step(ma, start_a, halt_a, 2, 64'hFFFF_FFFF, 50);
      mb <= model_step(mb, start_b, halt_b, 2, 15, 0);
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Every-cycle comparison of both DUTs against the model.
  always @(negedge Clk) begin
    chk("a.core_rst", 64'(core_rst_a), ma.running ? 64'd0 : 64'd3);
    chk("a.run",      64'(run_a),      64'(ma.running));
    chk("a.halted",   64'(halted_a),   64'(ma.halted));
    chk("a.cycle_cnt",64'(cnt_a),      64'(ma.cnt));
    chk("a.done",     64'(done_a),     64'(ma.done));
    chk("a.timeout",  64'(tmo_a),      64'(ma.tmo));
    chk("b.core_rst", 64'(core_rst_b), mb.running ? 64'd0 : 64'd3);
    chk("b.run",      64'(run_b),      64'(mb.running));
    chk("b.cycle_cnt",64'(cnt_b),      64'(mb.cnt));
    chk("b.done",     64'(done_b),     64'(mb.done));
    chk("b.timeout",  64'(tmo_b),      64'(mb.tmo));
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_cnt_a(input longint target);
    int guard = 0;
    while (!(ma.running && ma.cnt == target) && guard < 200) begin
      tick();
      guard++;
    end
    if (guard >= 200) bound_fail("wait_cnt_a");
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    repeat (3) tick();
    Reset = 1'b1;
    chk("rst.core_rst", 64'(core_rst_a), 64'd3);
    chk("rst.run",      64'(run_a),      64'd0);
    chk("rst.cnt",      64'(cnt_a),      64'd0);
    chk("rst.dbg",      64'(dbg_a),      64'(ST_IDLE));

    // Start after reset release; a second start during the reset hold is ignored.
    repeat (4) tick();
    pulse_start_a();
    chk("hold1.core_rst", 64'(core_rst_a), 64'd3);
    chk("hold1.run",      64'(run_a),      64'd0);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("hold2.core_rst", 64'(core_rst_a), 64'd3);
    chk("hold2.run",      64'(run_a),      64'd0);
    tick();
    chk("entry.run",      64'(run_a),      64'd1);
    chk("entry.core_rst", 64'(core_rst_a), 64'd0);
    chk("entry.cnt",      64'(cnt_a),      64'd0);

    // Staggered halts: core 0 at count 10, core 1 at count 20.
    repeat (5) tick();
    pulse_start_a();
    wait_cnt_a(10);
    halt_a = 2'b01; tick(); halt_a = 2'b00;
    chk("halt0.halted", 64'(halted_a), 64'd1);
    chk("halt0.done",   64'(done_a),   64'd0);
    wait_cnt_a(20);
    halt_a = 2'b10; tick(); halt_a = 2'b00;
    chk("done.halted", 64'(halted_a), 64'd3);
    chk("done.done",   64'(done_a),   64'd1);
    chk("done.run",    64'(run_a),    64'd0);
    chk("done.cnt",    64'(cnt_a),    64'd21);
    chk("done.dbg",    64'(dbg_a),    64'(ST_DONE));
    halt_a = 2'b11; repeat (2) tick(); halt_a = 2'b00;
    chk("done.frozen", 64'(cnt_a), 64'd21);

    // No halts: watchdog fires after count 49.
    pulse_start_a();
    chk("restart.done", 64'(done_a), 64'd0);
    repeat (2) tick();
    wait_cnt_a(49);
    tick();
    chk("tmo.timeout",  64'(tmo_a),      64'd1);
    chk("tmo.run",      64'(run_a),      64'd0);
    chk("tmo.core_rst", 64'(core_rst_a), 64'd3);
    chk("tmo.done",     64'(done_a),     64'd0);
    halt_a = 2'b11; tick(); halt_a = 2'b00;
    chk("tmo.halt_ignored", 64'(halted_a), 64'd0);

    // Last halt in the watchdog cycle: completion wins.
    pulse_start_a();
    chk("restart.timeout", 64'(tmo_a), 64'd0);
    repeat (2) tick();
    wait_cnt_a(5);
    halt_a = 2'b10; tick(); halt_a = 2'b00;
    wait_cnt_a(49);
    halt_a = 2'b01; tick(); halt_a = 2'b00;
    chk("race.done",    64'(done_a),   64'd1);
    chk("race.timeout", 64'(tmo_a),    64'd0);
    chk("race.halted",  64'(halted_a), 64'd3);
    chk("race.cnt",     64'(cnt_a),    64'd50);

    // Reset mid-run aborts everything immediately.
    pulse_start_a();
    repeat (2) tick();
    wait_cnt_a(3);
    halt_a = 2'b01; tick(); halt_a = 2'b00;
    wait_cnt_a(7);
    Reset = 1'b0;
    #1;
    chk("abort.core_rst", 64'(core_rst_a), 64'd3);
    chk("abort.run",      64'(run_a),      64'd0);
    chk("abort.halted",   64'(halted_a),   64'd0);
    chk("abort.cnt",      64'(cnt_a),      64'd0);
    chk("abort.done",     64'(done_a),     64'd0);
    chk("abort.timeout",  64'(tmo_a),      64'd0);
    repeat (2) tick();
    Reset = 1'b1;
    repeat (2) tick();
    chk("abort.idle_run", 64'(run_a), 64'd0);
    pulse_start_a();
    repeat (2) tick();
    chk("clean.run",    64'(run_a),    64'd1);
    chk("clean.cnt",    64'(cnt_a),    64'd0);
    chk("clean.halted", 64'(halted_a), 64'd0);

    // Narrow counter without watchdog saturates; start pulses in RUN are ignored.
    start_b = 1'b1; tick(); start_b = 1'b0;
    repeat (2) tick();
    chk("sat.entry_run", 64'(run_b), 64'd1);
    chk("sat.entry_cnt", 64'(cnt_b), 64'd0);
    for (int i = 0; i < 30; i++) begin
      start_b = (i % 7 == 3);
      tick();
    end
    start_b = 1'b0;
    chk("sat.cnt",      64'(cnt_b),      64'd15);
    chk("sat.run",      64'(run_b),      64'd1);
    chk("sat.core_rst", 64'(core_rst_b), 64'd0);
    chk("sat.timeout",  64'(tmo_b),      64'd0);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
